// File: rtl/lifo_pkg.sv
// Shared types and width helpers for the register-topped LIFO.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_e;

  // Occupancy must be able to hold DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_spill_mem.sv
// Spill storage below the TOS register: one synchronous write port, one asynchronous read port.
module lifo_spill_mem #(
  parameter int DEPTH      = 31,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; occupancy tracks which entries are live.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_tos.sv
// LIFO with a registered top-of-stack, valid/ready on both sides, replace-top,
// occupancy flags, synchronous flush and a high-water-mark tracker.
module lifo_tos
  import lifo_pkg::*;
#(
  parameter int DEPTH           = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ALMOST_FULL_TH  = DEPTH - 4,
  parameter int ALMOST_EMPTY_TH = 4,
  localparam int CNT_W          = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  clear_i,
  input  logic                  hwm_clear_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      high_water_o
);

  localparam int MEM_D  = DEPTH - 1;
  localparam int MEM_AW = (MEM_D > 1) ? $clog2(MEM_D) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY_TH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      hwm_q, hwm_d;
  logic [DATA_WIDTH-1:0] tos_q, tos_d;
  logic                  push_fire_s, pop_fire_s;
  stack_op_e             op_s;
  logic                  mem_we_s;
  logic [MEM_AW-1:0]     mem_waddr_s, mem_raddr_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;

  assign empty_o        = (count_q == {CNT_W{1'b0}});
  assign full_o         = (count_q == DEPTH_C);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign count_o        = count_q;
  assign high_water_o   = hwm_q;
  assign pop_data_o     = tos_q;

  // Readiness looks only at our own state and the flush, never at the far side's handshake.
  assign push_ready_o = ~full_o & ~clear_i;
  assign pop_valid_o  = ~empty_o & ~clear_i;
  assign push_fire_s  = push_valid_i & push_ready_o;
  assign pop_fire_s   = pop_valid_o & pop_ready_i;

  // The element under TOS lives at count-1 when spilling and is read back from count-2.
  assign mem_waddr_s = MEM_AW'(count_q - ONE_C);
  assign mem_raddr_s = MEM_AW'(count_q - TWO_C);

  // Decode the two handshakes into one stack operation.
  always_comb begin
    op_s = OP_NONE;
    case ({push_fire_s, pop_fire_s})
      2'b10:   op_s = OP_PUSH;
      2'b01:   op_s = OP_POP;
      2'b11:   op_s = OP_REPLACE;
      default: op_s = OP_NONE;
    endcase
  end

  // Next-state for count, TOS and the spill write strobe; flush overrides everything.
  always_comb begin
    count_d  = count_q;
    tos_d    = tos_q;
    mem_we_s = 1'b0;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
      tos_d   = {DATA_WIDTH{1'b0}};
    end else begin
      case (op_s)
        OP_PUSH: begin
          mem_we_s = (count_q != {CNT_W{1'b0}});
          tos_d    = push_data_i;
          count_d  = count_q + ONE_C;
        end
        OP_POP: begin
          tos_d   = (count_q > ONE_C) ? mem_rdata_s : {DATA_WIDTH{1'b0}};
          count_d = count_q - ONE_C;
        end
        OP_REPLACE: begin
          tos_d = push_data_i;
        end
        default: begin
          tos_d = tos_q;
        end
      endcase
    end
  end

  // Clearing the high-water mark restarts it from the occupancy being entered, not zero.
  always_comb begin
    if (hwm_clear_i) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end else begin
      hwm_d = hwm_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= {CNT_W{1'b0}};
      tos_q   <= {DATA_WIDTH{1'b0}};
      hwm_q   <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      hwm_q   <= hwm_d;
    end
  end

  lifo_spill_mem #(
    .DEPTH      (MEM_D),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_spill (
    .clk_i   (clk_i),
    .we_i    (mem_we_s),
    .waddr_i (mem_waddr_s),
    .wdata_i (tos_q),
    .raddr_i (mem_raddr_s),
    .rdata_o (mem_rdata_s)
  );

endmodule

// File: tb/tb_lifo_tos.sv
// Table-driven check of lifo_tos (DEPTH=4, AF=3, AE=1) with a popped-data scoreboard.
module tb_lifo_tos;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       clear_i, hwm_clear_i, push_valid_i, pop_ready_i;
  logic [7:0] push_data_i;
  logic       push_ready_o, pop_valid_o;
  logic [7:0] pop_data_o;
  logic [2:0] count_o, high_water_o;
  logic       empty_o, full_o, almost_full_o, almost_empty_o;

  int total = 0;
  int bad   = 0;

  lifo_tos #(
    .DEPTH(4), .DATA_WIDTH(8), .ALMOST_FULL_TH(3), .ALMOST_EMPTY_TH(1)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .hwm_clear_i(hwm_clear_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_data_i(push_data_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i), .pop_data_o(pop_data_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .high_water_o(high_water_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       clr, hclr, pv;
    logic [7:0] pd;
    logic       pr;
    logic       e_prdy, e_pvld;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
    logic       e_full, e_empty, e_af, e_ae;
    logic [2:0] e_hwm;
  } vec_t;

  vec_t       vecs[26];
  logic [7:0] model[$];
  logic [7:0] sb[$];

  function automatic vec_t mk(input int clr, input int hclr, input int pv, input int pd, input int pr,
                              input int prdy, input int pvld, input int data,
                              input int cnt, input int full, input int empty, input int af,
                              input int ae, input int hwm);
    vec_t v;
    v.clr = 1'(clr); v.hclr = 1'(hclr); v.pv = 1'(pv); v.pd = 8'(pd); v.pr = 1'(pr);
    v.e_prdy = 1'(prdy); v.e_pvld = 1'(pvld); v.e_data = 8'(data);
    v.e_cnt = 3'(cnt); v.e_full = 1'(full); v.e_empty = 1'(empty);
    v.e_af = 1'(af); v.e_ae = 1'(ae); v.e_hwm = 3'(hwm);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    bit m_push, m_pop;
    @(negedge clk_i);
    clear_i = v.clr; hwm_clear_i = v.hclr; push_valid_i = v.pv; push_data_i = v.pd; pop_ready_i = v.pr;
    m_push = !v.clr && v.pv && (model.size() < 4);
    m_pop  = !v.clr && v.pr && (model.size() > 0);
    if (m_pop) sb.push_back(model[model.size()-1]);
    if (v.clr) model.delete();
    else if (m_push && m_pop) model[model.size()-1] = v.pd;
    else if (m_push) model.push_back(v.pd);
    else if (m_pop) void'(model.pop_back());
    #2;
    chk({tag, " push_ready"}, 32'(push_ready_o), 32'(v.e_prdy));
    chk({tag, " pop_valid"},  32'(pop_valid_o),  32'(v.e_pvld));
    chk({tag, " pop_data"},   32'(pop_data_o),   32'(v.e_data));
    if (pop_valid_o && pop_ready_i) begin
      if (sb.size() == 0) chk({tag, " sb_unexpected_pop"}, 32'(1), 32'(0));
      else chk({tag, " sb_popped"}, 32'(pop_data_o), 32'(sb.pop_front()));
    end
    @(posedge clk_i); #1;
    chk({tag, " count"},        32'(count_o),        32'(v.e_cnt));
    chk({tag, " full"},         32'(full_o),         32'(v.e_full));
    chk({tag, " empty"},        32'(empty_o),        32'(v.e_empty));
    chk({tag, " almost_full"},  32'(almost_full_o),  32'(v.e_af));
    chk({tag, " almost_empty"}, 32'(almost_empty_o), 32'(v.e_ae));
    chk({tag, " high_water"},   32'(high_water_o),   32'(v.e_hwm));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"},        32'(count_o),        32'(0));
    chk({tag, " empty"},        32'(empty_o),        32'(1));
    chk({tag, " full"},         32'(full_o),         32'(0));
    chk({tag, " almost_empty"}, 32'(almost_empty_o), 32'(1));
    chk({tag, " almost_full"},  32'(almost_full_o),  32'(0));
    chk({tag, " pop_data"},     32'(pop_data_o),     32'(0));
    chk({tag, " high_water"},   32'(high_water_o),   32'(0));
  endtask

  initial begin
    //               clr hclr pv pd    pr  prdy pvld data  cnt f e af ae hwm
    vecs[0]  = mk(0, 0, 1, 'hA1, 0,  1, 0, 'h00,  1, 0, 0, 0, 1, 1);
    vecs[1]  = mk(0, 0, 1, 'hA2, 0,  1, 1, 'hA1,  2, 0, 0, 0, 0, 2);
    vecs[2]  = mk(0, 0, 1, 'hA3, 0,  1, 1, 'hA2,  3, 0, 0, 1, 0, 3);
    vecs[3]  = mk(0, 0, 1, 'hA4, 0,  1, 1, 'hA3,  4, 1, 0, 1, 0, 4);
    vecs[4]  = mk(0, 0, 1, 'h55, 0,  0, 1, 'hA4,  4, 1, 0, 1, 0, 4);
    vecs[5]  = mk(0, 0, 0, 'h00, 1,  0, 1, 'hA4,  3, 0, 0, 1, 0, 4);
    vecs[6]  = mk(0, 0, 0, 'h00, 1,  1, 1, 'hA3,  2, 0, 0, 0, 0, 4);
    vecs[7]  = mk(0, 0, 0, 'h00, 1,  1, 1, 'hA2,  1, 0, 0, 0, 1, 4);
    vecs[8]  = mk(0, 0, 0, 'h00, 1,  1, 1, 'hA1,  0, 0, 1, 0, 1, 4);
    vecs[9]  = mk(0, 0, 0, 'h00, 1,  1, 0, 'h00,  0, 0, 1, 0, 1, 4);
    vecs[10] = mk(0, 0, 1, 'hB1, 0,  1, 0, 'h00,  1, 0, 0, 0, 1, 4);
    vecs[11] = mk(0, 0, 1, 'hB2, 0,  1, 1, 'hB1,  2, 0, 0, 0, 0, 4);
    vecs[12] = mk(0, 0, 1, 'hC0, 1,  1, 1, 'hB2,  2, 0, 0, 0, 0, 4);
    vecs[13] = mk(0, 0, 0, 'h00, 1,  1, 1, 'hC0,  1, 0, 0, 0, 1, 4);
    vecs[14] = mk(0, 0, 0, 'h00, 1,  1, 1, 'hB1,  0, 0, 1, 0, 1, 4);
    vecs[15] = mk(0, 1, 0, 'h00, 0,  1, 0, 'h00,  0, 0, 1, 0, 1, 0);
    vecs[16] = mk(0, 0, 1, 'hA1, 0,  1, 0, 'h00,  1, 0, 0, 0, 1, 1);
    vecs[17] = mk(0, 0, 1, 'hA2, 0,  1, 1, 'hA1,  2, 0, 0, 0, 0, 2);
    vecs[18] = mk(0, 0, 1, 'hA3, 0,  1, 1, 'hA2,  3, 0, 0, 1, 0, 3);
    vecs[19] = mk(0, 0, 1, 'hA4, 0,  1, 1, 'hA3,  4, 1, 0, 1, 0, 4);
    vecs[20] = mk(0, 0, 1, 'h77, 1,  0, 1, 'hA4,  3, 0, 0, 1, 0, 4);
    vecs[21] = mk(0, 1, 0, 'h00, 0,  1, 1, 'hA3,  3, 0, 0, 1, 0, 3);
    vecs[22] = mk(1, 0, 1, 'h88, 1,  0, 0, 'hA3,  0, 0, 1, 0, 1, 3);
    vecs[23] = mk(0, 1, 0, 'h00, 0,  1, 0, 'h00,  0, 0, 1, 0, 1, 0);
    vecs[24] = mk(0, 0, 1, 'hF1, 0,  1, 0, 'h00,  1, 0, 0, 0, 1, 1);
    vecs[25] = mk(0, 0, 1, 'hF2, 0,  1, 1, 'hF1,  2, 0, 0, 0, 0, 2);

    reset_ni = 1'b0; clear_i = 1'b0; hwm_clear_i = 1'b0;
    push_valid_i = 1'b0; push_data_i = 8'h00; pop_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_state("reset");
    @(negedge clk_i);
    reset_ni = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-cycle, well clear of any clock edge.
    push_valid_i = 1'b0; pop_ready_i = 1'b0;
    #1;
    reset_ni = 1'b0;
    #1;
    chk_reset_state("async_reset");
    model.delete();
    chk("sb_drained", 32'(sb.size()), 32'(0));
    sb.delete();
    @(negedge clk_i);
    reset_ni = 1'b1;
    apply("post_reset_push", mk(0, 0, 1, 'hD0, 0, 1, 0, 'h00, 1, 0, 0, 0, 1, 1));
    apply("post_reset_show", mk(0, 0, 0, 'h00, 0, 1, 1, 'hD0, 1, 0, 0, 0, 1, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lifo_tos.md
Name: lifo_tos

Overview:
- Parametrised successor to the basic LIFO: a stack whose top-of-stack is held in a register, with valid/ready handshakes on both sides.
- Adds same-cycle push+pop "replace-top", an occupancy count, almost-full/almost-empty thresholds, a synchronous flush and a high-water-mark counter.
- Sits between a producer and a consumer that need last-in-first-out ordering, e.g. return-address or context stacks in datapath control.

Parameters:
- DEPTH, 32, total element capacity including the TOS register; legal range DEPTH >= 2.
- DATA_WIDTH, 32, element width in bits.
- ALMOST_FULL_TH, DEPTH-4, almost_full_o asserts when count >= this value.
- ALMOST_EMPTY_TH, 4, almost_empty_o asserts when count <= this value.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush; takes priority over push and pop.
- hwm_clear_i  in  1  synchronous clear of the high-water mark.
- push_valid_i  in  1  producer offers push_data_i.
- push_ready_o  out  1  = ~full_o & ~clear_i.
- push_data_i  in  DATA_WIDTH  element to push.
- pop_valid_o  out  1  = ~empty_o & ~clear_i.
- pop_ready_i  in  1  consumer takes the top element.
- pop_data_o  out  DATA_WIDTH  current top element; driven directly from the TOS register.
- count_o  out  CNT_W  occupancy, where CNT_W = $clog2(DEPTH+1).
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.
- almost_full_o  out  1  count >= ALMOST_FULL_TH.
- almost_empty_o  out  1  count <= ALMOST_EMPTY_TH.
- high_water_o  out  CNT_W  maximum count reached since reset or since the last hwm_clear_i.

Behaviour:
- Reset (reset_ni low, asynchronous): count = 0, tos = 0, hwm = 0.
  - Outputs after reset: empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0 (for TH > 0), pop_data_o = 0.
  - Spill memory contents are not reset.
  - Reset asserted mid-operation discards everything; no partial update survives.
- Handshake rules:
  - push_fire = push_valid_i & push_ready_o; pop_fire = pop_valid_o & pop_ready_i.
  - push_ready_o and pop_valid_o never depend on the opposite handshake: no path from pop_ready_i to push_ready_o.
  - Consequence: when full, a push is refused even if a pop fires in the same cycle.
- Storage: TOS register plus a spill memory of DEPTH-1 entries (synchronous write, asynchronous read), indexed by count-1 / count-2.
- Operations, decided per cycle (priority order):
  - CLEAR (clear_i = 1): count <= 0, tos <= 0. Any offered push/pop is ignored; readies/valids are already low.
  - PUSH (push_fire only): if count > 0 then mem[count-1] <= tos. Then tos <= push_data_i, count <= count+1.
  - POP (pop_fire only): pop_data_o shows the old tos this cycle. If count > 1 then tos <= mem[count-2], else tos <= 0. count <= count-1.
  - REPLACE (push_fire & pop_fire, only possible when 0 < count < DEPTH): consumer receives the old tos; tos <= push_data_i; count and memory unchanged.
  - NONE: hold all state.
- Latency: a pushed element appears on pop_data_o in the next cycle; a pop exposes the next element in the next cycle.
- Flags and count_o are combinational from the count register, so they update the cycle after the operation.
- High-water mark:
  - hwm <= max(hwm, next_count) every cycle.
  - hwm_clear_i sets hwm <= next_count (not 0); it is independent of clear_i.
- Widths: count uses CNT_W bits, so full at DEPTH never wraps. Memory address width is $clog2(DEPTH-1), minimum 1.

Decomposition:
- Package lifo_pkg holds:
  - typedef enum logic [1:0] stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE};
  - a function cnt_width(depth), used to derive CNT_W.
- One sub-module, lifo_spill_mem: parametrised by DEPTH-1 and DATA_WIDTH, one synchronous write port, one asynchronous read port.
- lifo_tos contains the op decoder, count, TOS and hwm registers.

Test Plan (all with DEPTH=4, AF=3, AE=1):
- Reset, then push 0xA1, 0xA2, 0xA3, 0xA4 -> count_o 1..4; full_o=1 and push_ready_o=0 after the 4th; almost_full_o=1 from count 3; pop_data_o=0xA4.
- Pop 4 times from full -> data 0xA4, 0xA3, 0xA2, 0xA1 in order; then empty_o=1, pop_valid_o=0, pop_data_o=0; high_water_o=4.
- With count 2 (top 0xB2), push 0xC0 and pop in the same cycle -> consumer gets 0xB2; next cycle pop_data_o=0xC0, count_o=2; a following pop gives 0xC0 and then 0xB1.
- Full stack, push_valid_i=1 and pop_ready_i=1 -> only the pop fires (0xA4 out); count_o=3; pushed data is not taken.
- count 3, assert clear_i with push_valid_i=1 -> push_ready_o=0 that cycle; next cycle count_o=0, empty_o=1; high_water_o stays 3. Then hwm_clear_i -> high_water_o=0.
- After two pushes, drop reset_ni low asynchronously mid-cycle -> outputs return to reset values immediately, with no clock edge; after release, the first push of 0xD0 gives pop_data_o=0xD0, count_o=1.
